otsu_threshold_ctrl: RTL and testbench

//  Sequencer for the Otsu threshold search. After the histogram of max_value samples is complete, it reads the

---
 rtl/otsu_threshold_ctrl_pkg.sv | 33 +++
 rtl/otsu_between_var.sv | 65 ++++++
 rtl/otsu_threshold_ctrl.sv | 170 +++++++++++++++++
 tb/tb_otsu_threshold_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/otsu_threshold_ctrl_pkg.sv
// Shared configuration, derived widths and types for the Otsu threshold sequencer.
// CMP_W must hold num*den exactly so the cross-multiply compare never truncates.
package otsu_threshold_ctrl_pkg;

    localparam int VALUE_WIDTH = 8;
    localparam int CNT_WIDTH   = 16;
    localparam int VAR_LAT     = 4;

    localparam int N_BINS = 1 << VALUE_WIDTH;
    localparam int SUM_W  = CNT_WIDTH + VALUE_WIDTH;
    localparam int PROD_W = SUM_W + CNT_WIDTH;
    localparam int NUM_W  = 2 * PROD_W;
    localparam int DEN_W  = 2 * CNT_WIDTH;
    localparam int CMP_W  = NUM_W + DEN_W;

    // Read return, candidate present and best-register update add three cycles to the pipeline latency.
    localparam int DRAIN_CYC = VAR_LAT + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [VALUE_WIDTH-1:0] t;
        logic [DEN_W-1:0]       den;
        logic                   invalid;
    } cand_side_t;

endpackage

// File: rtl/otsu_between_var.sv
// Pipelined between-class variance terms: num = (S_T*w0 - W*s0)^2, den = w0*(W-w0).
// Four register stages, one candidate per cycle.
module otsu_between_var
    import otsu_threshold_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [VALUE_WIDTH-1:0] in_t,
    input  logic [CNT_WIDTH-1:0]   w0,
    input  logic [SUM_W-1:0]       s0,
    input  logic [CNT_WIDTH-1:0]   w_tot,
    input  logic [SUM_W-1:0]       s_tot,
    output logic                   out_valid,
    output logic [VALUE_WIDTH-1:0] out_t,
    output logic [NUM_W-1:0]       out_num,
    output logic [DEN_W-1:0]       out_den,
    output logic                   out_invalid
);

    logic              s1_valid, s2_valid, s3_valid;
    cand_side_t        s1_side, s2_side, s3_side, s4_side;
    logic [PROD_W-1:0] s1_a, s1_b;
    logic [PROD_W-1:0] s2_diff;
    logic [NUM_W-1:0]  s3_num;
    logic [NUM_W-1:0]  s4_num;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
        end
    end

    // NOTE: datapath stages carry no reset; the valid chain alone qualifies them.
    always_ff @(posedge clk) begin
        s1_a            <= PROD_W'(s_tot) * PROD_W'(w0);
        s1_b            <= PROD_W'(w_tot) * PROD_W'(s0);
        s1_side.t       <= in_t;
        s1_side.den     <= DEN_W'(w0) * DEN_W'(w_tot - w0);
        s1_side.invalid <= (w0 == '0) || (w0 == w_tot);

        s2_diff <= (s1_a >= s1_b) ? (s1_a - s1_b) : (s1_b - s1_a);
        s2_side <= s1_side;

        s3_num  <= NUM_W'(s2_diff) * NUM_W'(s2_diff);
        s3_side <= s2_side;

        s4_num  <= s3_num;
        s4_side <= s3_side;
    end

    assign out_t       = s4_side.t;
    assign out_den     = s4_side.den;
    assign out_invalid = s4_side.invalid;
    assign out_num     = s4_num;

endmodule

// File: rtl/otsu_threshold_ctrl.sv
// Otsu threshold sequencer: pass 1 totals the histogram, pass 2 sweeps every split and
// keeps the one with maximum between-class variance using a division-free compare.
module otsu_threshold_ctrl
    import otsu_threshold_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   hist_rd_en,
    output logic [VALUE_WIDTH-1:0] hist_rd_addr,
    input  logic [CNT_WIDTH-1:0]   hist_rd_data,
    output logic [VALUE_WIDTH-1:0] threshold,
    output logic                   degenerate,
    output logic                   done
);

    localparam logic [VALUE_WIDTH-1:0] LAST_SUM_ADDR   = VALUE_WIDTH'(N_BINS - 1);
    localparam logic [VALUE_WIDTH-1:0] LAST_SWEEP_ADDR = VALUE_WIDTH'(N_BINS - 2);
    localparam logic [3:0]             DRAIN_LAST      = 4'(DRAIN_CYC - 1);

    state_t state_q, state_d;
    logic [3:0] drain_cnt_q;
    logic       start_acc;

    logic                   rd_pend_q, rd_sweep_q;
    logic [VALUE_WIDTH-1:0] rd_addr_q;

    logic [CNT_WIDTH-1:0]   w_tot_q, w0_q;
    logic [SUM_W-1:0]       s_tot_q, s0_q;
    logic                   cand_valid_q;
    logic [VALUE_WIDTH-1:0] cand_t_q;

    logic                   bv_valid, bv_invalid;
    logic [VALUE_WIDTH-1:0] bv_t;
    logic [NUM_W-1:0]       bv_num;
    logic [DEN_W-1:0]       bv_den;

    logic                   best_valid_q;
    logic [VALUE_WIDTH-1:0] best_t_q;
    logic [NUM_W-1:0]       best_num_q;
    logic [DEN_W-1:0]       best_den_q;
    logic [CMP_W-1:0]       cand_lhs, best_rhs;
    logic                   cand_wins;

    assign start_acc = (state_q == ST_IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SUM;
            ST_SUM:   if (hist_rd_addr == LAST_SUM_ADDR) state_d = ST_SWEEP;
            ST_SWEEP: if (hist_rd_addr == LAST_SWEEP_ADDR) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        hist_rd_en = (state_q == ST_SUM) || (state_q == ST_SWEEP);
        done       = (state_q == ST_DONE);
    end

    // The address wraps 255 -> 0 between passes and holds once the sweep has issued its last bin.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_rd_addr <= '0;
            drain_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) hist_rd_addr <= '0;
                ST_SUM:   hist_rd_addr <= hist_rd_addr + VALUE_WIDTH'(1);
                ST_SWEEP: begin
                    drain_cnt_q <= '0;
                    if (state_d == ST_SWEEP) hist_rd_addr <= hist_rd_addr + VALUE_WIDTH'(1);
                end
                ST_DRAIN: drain_cnt_q <= drain_cnt_q + 4'd1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q    <= 1'b0;
            rd_sweep_q   <= 1'b0;
            rd_addr_q    <= '0;
            cand_valid_q <= 1'b0;
            cand_t_q     <= '0;
        end else begin
            rd_pend_q    <= hist_rd_en;
            rd_sweep_q   <= (state_q == ST_SWEEP);
            rd_addr_q    <= hist_rd_addr;
            cand_valid_q <= rd_pend_q && rd_sweep_q;
            cand_t_q     <= rd_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            w_tot_q <= '0;
            s_tot_q <= '0;
            w0_q    <= '0;
            s0_q    <= '0;
        end else if (rd_pend_q) begin
            if (!rd_sweep_q) begin
                w_tot_q <= w_tot_q + hist_rd_data;
                s_tot_q <= s_tot_q + (SUM_W'(rd_addr_q) * SUM_W'(hist_rd_data));
            end else begin
                w0_q <= w0_q + hist_rd_data;
                s0_q <= s0_q + (SUM_W'(rd_addr_q) * SUM_W'(hist_rd_data));
            end
        end
    end

    otsu_between_var u_between_var (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (cand_valid_q),
        .in_t        (cand_t_q),
        .w0          (w0_q),
        .s0          (s0_q),
        .w_tot       (w_tot_q),
        .s_tot       (s_tot_q),
        .out_valid   (bv_valid),
        .out_t       (bv_t),
        .out_num     (bv_num),
        .out_den     (bv_den),
        .out_invalid (bv_invalid)
    );

    // num_c/den_c > num_b/den_b without division; strict '>' keeps the smallest t on ties.
    assign cand_lhs  = CMP_W'(bv_num) * CMP_W'(best_den_q);
    assign best_rhs  = CMP_W'(best_num_q) * CMP_W'(bv_den);
    assign cand_wins = bv_valid && !bv_invalid && (!best_valid_q || (cand_lhs > best_rhs));

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            best_valid_q <= 1'b0;
            best_t_q     <= '0;
            best_num_q   <= '0;
            best_den_q   <= '0;
        end else if (cand_wins) begin
            best_valid_q <= 1'b1;
            best_t_q     <= bv_t;
            best_num_q   <= bv_num;
            best_den_q   <= bv_den;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            threshold  <= '0;
            degenerate <= 1'b0;
        end else if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
            threshold  <= best_valid_q ? best_t_q : '0;
            degenerate <= !best_valid_q;
        end
    end

endmodule

// File: tb/tb_otsu_threshold_ctrl.sv
// Self-checking bench for otsu_threshold_ctrl: directed Otsu cases plus random histograms
// compared against an exhaustive between-class-variance search over all splits.
module tb_otsu_threshold_ctrl;
    import otsu_threshold_ctrl_pkg::*;

    localparam int DONE_CYC = 2 * N_BINS + VAR_LAT + 3;
    localparam int N_READS  = 2 * N_BINS - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   busy;
    logic                   hist_rd_en;
    logic [VALUE_WIDTH-1:0] hist_rd_addr;
    logic [CNT_WIDTH-1:0]   hist_rd_data;
    logic [VALUE_WIDTH-1:0] threshold;
    logic                   degenerate;
    logic                   done;

    int unsigned hist [N_BINS];
    int          rd_log [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    otsu_threshold_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .hist_rd_en   (hist_rd_en),
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data),
        .threshold    (threshold),
        .degenerate   (degenerate),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Histogram RAM: one-cycle read latency, junk on the bus when not reading.
    always @(posedge clk)
        hist_rd_data <= hist_rd_en ? CNT_WIDTH'(hist[hist_rd_addr]) : CNT_WIDTH'($urandom);

    always @(negedge clk)
        if (hist_rd_en) rd_log.push_back(int'(hist_rd_addr));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Exhaustive search: maximise (S_T*w0 - W*s0)^2 / (w0*(W-w0)) over valid splits, first max wins.
    function automatic void model(output int thr, output bit degen);
        longint           w_all = 0, s_all = 0, w0 = 0, s0 = 0, d;
        logic [CMP_W-1:0] dv, num, den, best_num, best_den;
        bit               have = 0;
        best_num = '0;
        best_den = '0;
        thr = 0;
        for (int i = 0; i < N_BINS; i++) begin
            w_all += hist[i];
            s_all += longint'(i) * hist[i];
        end
        for (int t = 0; t < N_BINS - 1; t++) begin
            w0 += hist[t];
            s0 += longint'(t) * hist[t];
            if (w0 == 0 || w0 == w_all) continue;
            d = s_all * w0 - w_all * s0;
            if (d < 0) d = -d;
            dv  = CMP_W'(d);
            num = dv * dv;
            den = CMP_W'(w0 * (w_all - w0));
            if (!have || num * best_den > best_num * den) begin
                have     = 1;
                thr      = t;
                best_num = num;
                best_den = den;
            end
        end
        degen = !have;
    endfunction

    function automatic void clear_hist();
        for (int i = 0; i < N_BINS; i++) hist[i] = 0;
    endfunction

    function automatic void random_hist();
        clear_hist();
        if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < N_BINS; i++) hist[i] = $urandom_range(0, 200);
        end else begin
            int k = $urandom_range(1, 8);
            for (int j = 0; j < k; j++) hist[$urandom_range(0, N_BINS - 1)] = $urandom_range(1, 4000);
        end
    endfunction

    // Runs one search; start is re-pulsed in cycles p1/p2 (negative = never). Returns observed result.
    task automatic run(input string tag, input int p1, input int p2,
                       output int thr_obs, output bit deg_obs);
        int cyc = 0;
        bit seen = 0;
        bit busy_ok = 1;
        int errs = 0;
        int exp_thr;
        bit exp_deg;
        thr_obs = -1;
        deg_obs = 0;
        rd_log.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && cyc < DONE_CYC + 80) begin
            @(negedge clk);
            cyc++;
            start = (cyc == p1) || (cyc == p2);
            if (!busy) busy_ok = 0;
            if (done) begin
                seen    = 1;
                thr_obs = int'(threshold);
                deg_obs = degenerate;
            end
        end
        start = 1'b0;
        check({tag, "/done_seen"}, 64'(seen), 64'd1);
        check({tag, "/done_cycle"}, 64'(cyc), 64'(DONE_CYC));
        check({tag, "/busy_while_running"}, 64'(busy_ok), 64'd1);
        model(exp_thr, exp_deg);
        check({tag, "/threshold"}, 64'(thr_obs), 64'(exp_thr));
        check({tag, "/degenerate"}, 64'(deg_obs), 64'(exp_deg));
        check({tag, "/read_count"}, 64'(rd_log.size()), 64'(N_READS));
        foreach (rd_log[i]) begin
            if (rd_log[i] != ((i < N_BINS) ? i : i - N_BINS)) errs++;
        end
        check({tag, "/read_order_errors"}, 64'(errs), 64'd0);
        check({tag, "/addr_hold"}, 64'(hist_rd_addr), 64'(N_BINS - 2));
        @(posedge clk);
        #1;
        check({tag, "/done_single"}, 64'(done), 64'd0);
        check({tag, "/idle_after_done"}, 64'(busy), 64'd0);
    endtask

    task automatic set_case1();
        clear_hist();
        hist[50]  = 100;
        hist[100] = 100;
        hist[200] = 100;
    endtask

    initial begin
        int thr;
        bit deg;
        rst   = 1'b1;
        start = 1'b0;
        clear_hist();
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/rd_en", 64'(hist_rd_en), 64'd0);
        check("reset/rd_addr", 64'(hist_rd_addr), 64'd0);
        check("reset/threshold", 64'(threshold), 64'd0);
        check("reset/degenerate", 64'(degenerate), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_case1();
        run("three_bins", -1, -1, thr, deg);
        check("three_bins/thr_100", 64'(thr), 64'd100);
        check("three_bins/deg_0", 64'(deg), 64'd0);

        clear_hist();
        hist[10]  = 50;
        hist[200] = 50;
        run("tie", -1, -1, thr, deg);
        check("tie/thr_10", 64'(thr), 64'd10);

        clear_hist();
        run("empty", -1, -1, thr, deg);
        check("empty/thr_0", 64'(thr), 64'd0);
        check("empty/deg_1", 64'(deg), 64'd1);

        clear_hist();
        hist[77] = 300;
        run("one_bin", -1, -1, thr, deg);
        check("one_bin/thr_0", 64'(thr), 64'd0);
        check("one_bin/deg_1", 64'(deg), 64'd1);

        set_case1();
        run("repulse", 5, 300, thr, deg);
        check("repulse/thr_100", 64'(thr), 64'd100);

        // Abort mid-sweep, then a fresh run must still produce the undisturbed answer.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst/busy", 64'(busy), 64'd0);
        check("midrst/rd_en", 64'(hist_rd_en), 64'd0);
        check("midrst/threshold", 64'(threshold), 64'd0);
        check("midrst/degenerate", 64'(degenerate), 64'd0);
        check("midrst/done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst/stays_idle", 64'(busy), 64'd0);
        run("after_rst", -1, -1, thr, deg);
        check("after_rst/thr_100", 64'(thr), 64'd100);

        // Back-to-back random histograms: each run starts in the cycle after the previous done.
        for (int r = 0; r < 8; r++) begin
            random_hist();
            run($sformatf("rand%0d", r), -1, -1, thr, deg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
